// File: rtl/dma_engine.sv
// dma_engine: multi-channel memory-to-memory DMA engine.
// Each channel moves ch_len bytes from ch_src to ch_dst over the shared bus,
// one byte per four cycles (READ0, READ1, WRITE0, WRITE1). Channel 0 has the
// highest priority. A general channel runs to completion. An hblank channel
// moves BLOCK_BYTES per rising edge of hblank.
// Ports:
//   clk, reset (synchronous, active-low)
//   ch_start/ch_abort/ch_mode : per-channel control (mode 1 = hblank-paced)
//   ch_src/ch_dst/ch_len      : per-channel packed source, destination, length
//   hblank                    : PPU hblank level
//   bus_active/bus_addr/bus_data_w/bus_do_write : registered bus master outputs
//   bus_data_r                : read data, valid 2 cycles after bus_addr
//   ch_busy/ch_done           : per-channel status; done is a one-cycle pulse
module dma_engine #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned BLOCK_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_start,
  input  logic [NUM_CH-1:0]       ch_abort,
  input  logic [NUM_CH-1:0]       ch_mode,
  input  logic [16*NUM_CH-1:0]    ch_src,
  input  logic [16*NUM_CH-1:0]    ch_dst,
  input  logic [LEN_W*NUM_CH-1:0] ch_len,
  input  logic                    hblank,
  output logic                    bus_active,
  output logic [15:0]             bus_addr,
  output logic [7:0]              bus_data_w,
  output logic                    bus_do_write,
  input  logic [7:0]              bus_data_r,
  output logic [NUM_CH-1:0]       ch_busy,
  output logic [NUM_CH-1:0]       ch_done
);

  localparam int unsigned BLK_W = $clog2(BLOCK_BYTES + 1);
  localparam int unsigned CUR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ0,
    S_READ1,
    S_WRITE0,
    S_WRITE1
  } state_t;

  state_t               state_q, state_d;
  logic [CUR_W-1:0]     cur_q, cur_d;
  logic                 abort_cur_q, abort_cur_d;
  logic                 hblank_q, hblank_d;
  logic                 bus_active_q, bus_active_d;
  logic [15:0]          bus_addr_q, bus_addr_d;
  logic [7:0]           bus_data_w_q, bus_data_w_d;
  logic                 bus_do_write_q, bus_do_write_d;
  logic [NUM_CH-1:0]    busy_q, busy_d;
  logic [NUM_CH-1:0]    done_q, done_d;
  logic [NUM_CH-1:0]    mode_q, mode_d;
  logic [NUM_CH-1:0]    pending_q, pending_d;
  logic [15:0]          src_q [NUM_CH];
  logic [15:0]          src_d [NUM_CH];
  logic [15:0]          dst_q [NUM_CH];
  logic [15:0]          dst_d [NUM_CH];
  logic [LEN_W-1:0]     rem_q [NUM_CH];
  logic [LEN_W-1:0]     rem_d [NUM_CH];
  logic [LEN_W-1:0]     idx_q [NUM_CH];
  logic [LEN_W-1:0]     idx_d [NUM_CH];
  logic [BLK_W-1:0]     blk_q [NUM_CH];
  logic [BLK_W-1:0]     blk_d [NUM_CH];

  logic                 hb_rise;
  logic [NUM_CH-1:0]    ready;
  logic [CUR_W-1:0]     sel;
  logic                 sel_vld;
  logic [LEN_W-1:0]     idx_nxt;
  logic [BLK_W-1:0]     blk_nxt;

  // Next-state logic: channel bookkeeping first, then the bus sequencer.
  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    abort_cur_d    = abort_cur_q;
    hblank_d       = hblank;
    bus_active_d   = bus_active_q;
    bus_addr_d     = bus_addr_q;
    bus_data_w_d   = bus_data_w_q;
    bus_do_write_d = bus_do_write_q;
    busy_d         = busy_q;
    done_d         = '0;
    mode_d         = mode_q;
    pending_d      = pending_q;
    src_d          = src_q;
    dst_d          = dst_q;
    rem_d          = rem_q;
    idx_d          = idx_q;
    blk_d          = blk_q;
    hb_rise        = hblank & ~hblank_q;
    ready          = '0;
    sel            = '0;
    sel_vld        = 1'b0;
    idx_nxt        = idx_q[cur_q] + LEN_W'(1);
    blk_nxt        = blk_q[cur_q] + BLK_W'(1);

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      // A rising edge while already pending is simply absorbed.
      if (hb_rise && busy_q[i] && mode_q[i]) begin
        pending_d[i] = 1'b1;
      end
      // The executing channel finishes its byte; idle channels drop at once.
      if (ch_abort[i]) begin
        if ((state_q != S_IDLE) && (cur_q == CUR_W'(i))) begin
          abort_cur_d = 1'b1;
        end else begin
          busy_d[i]    = 1'b0;
          pending_d[i] = 1'b0;
        end
      end
      // Abort wins over start; a busy channel ignores start.
      if (ch_start[i] && !ch_abort[i] && !busy_q[i] &&
          (ch_len[LEN_W*i +: LEN_W] != '0)) begin
        src_d[i]     = ch_src[16*i +: 16];
        dst_d[i]     = ch_dst[16*i +: 16];
        rem_d[i]     = ch_len[LEN_W*i +: LEN_W];
        mode_d[i]    = ch_mode[i];
        idx_d[i]     = '0;
        blk_d[i]     = '0;
        pending_d[i] = 1'b0;
        busy_d[i]    = 1'b1;
      end
      ready[i] = busy_q[i] && !ch_abort[i] && (!mode_q[i] || pending_q[i]);
    end

    // Lowest index wins.
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel     = CUR_W'(i);
        sel_vld = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        bus_do_write_d = 1'b0;
        abort_cur_d    = 1'b0;
        if (sel_vld) begin
          cur_d        = sel;
          state_d      = S_READ0;
          bus_active_d = 1'b1;
          bus_addr_d   = src_q[sel] + 16'(idx_q[sel]);
        end else begin
          bus_active_d = 1'b0;
        end
      end
      S_READ0: begin
        bus_do_write_d = 1'b0;
        state_d        = S_READ1;
      end
      S_READ1: begin
        state_d = S_WRITE0;
      end
      S_WRITE0: begin
        // Read data for the address driven in READ0 is valid this cycle.
        bus_data_w_d   = bus_data_r;
        bus_addr_d     = dst_q[cur_q] + 16'(idx_q[cur_q]);
        bus_do_write_d = 1'b1;
        state_d        = S_WRITE1;
      end
      S_WRITE1: begin
        bus_do_write_d = 1'b0;
        idx_d[cur_q]   = idx_nxt;
        rem_d[cur_q]   = rem_q[cur_q] - LEN_W'(1);
        blk_d[cur_q]   = blk_nxt;
        if (abort_cur_d) begin
          busy_d[cur_q]    = 1'b0;
          pending_d[cur_q] = 1'b0;
          abort_cur_d      = 1'b0;
          bus_active_d     = 1'b0;
          state_d          = S_IDLE;
        end else if (rem_q[cur_q] == LEN_W'(1)) begin
          busy_d[cur_q]    = 1'b0;
          pending_d[cur_q] = 1'b0;
          done_d[cur_q]    = 1'b1;
          bus_active_d     = 1'b0;
          state_d          = S_IDLE;
        end else if (mode_q[cur_q] && (blk_nxt == BLK_W'(BLOCK_BYTES))) begin
          pending_d[cur_q] = 1'b0;
          blk_d[cur_q]     = '0;
          bus_active_d     = 1'b0;
          state_d          = S_IDLE;
        end else begin
          bus_addr_d = src_q[cur_q] + 16'(idx_nxt);
          state_d    = S_READ0;
        end
      end
      default: begin
        state_d      = S_IDLE;
        bus_active_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cur_q          <= '0;
      abort_cur_q    <= 1'b0;
      hblank_q       <= 1'b0;
      bus_active_q   <= 1'b0;
      bus_addr_q     <= '0;
      bus_data_w_q   <= '0;
      bus_do_write_q <= 1'b0;
      busy_q         <= '0;
      done_q         <= '0;
      mode_q         <= '0;
      pending_q      <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        rem_q[i] <= '0;
        idx_q[i] <= '0;
        blk_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      abort_cur_q    <= abort_cur_d;
      hblank_q       <= hblank_d;
      bus_active_q   <= bus_active_d;
      bus_addr_q     <= bus_addr_d;
      bus_data_w_q   <= bus_data_w_d;
      bus_do_write_q <= bus_do_write_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      mode_q         <= mode_d;
      pending_q      <= pending_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      rem_q          <= rem_d;
      idx_q          <= idx_d;
      blk_q          <= blk_d;
    end
  end

  assign bus_active   = bus_active_q;
  assign bus_addr     = bus_addr_q;
  assign bus_data_w   = bus_data_w_q;
  assign bus_do_write = bus_do_write_q;
  assign ch_busy      = busy_q;
  assign ch_done      = done_q;

endmodule
